// File: rtl/fmt_pkt_sink_if.sv
// Formatter packet interface plus the valid/ready output stream of fmt_pkt_sink.
// slave is the sink's view; master is the formatter/downstream side that drives it.
interface fmt_pkt_sink_if;
    logic        fmt_req_i;
    logic [1:0]  fmt_chid_i;
    logic [5:0]  fmt_length_i;
    logic        fmt_grant_o;
    logic        fmt_start_i;
    logic [31:0] fmt_data_i;
    logic        fmt_end_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_chid_o;
    logic        out_sop_o;
    logic        out_eop_o;

    modport slave (
        input  fmt_req_i, fmt_chid_i, fmt_length_i, fmt_start_i, fmt_data_i, fmt_end_i, out_rdy_i,
        output fmt_grant_o, out_vld_o, out_data_o, out_chid_o, out_sop_o, out_eop_o
    );

    modport master (
        output fmt_req_i, fmt_chid_i, fmt_length_i, fmt_start_i, fmt_data_i, fmt_end_i, out_rdy_i,
        input  fmt_grant_o, out_vld_o, out_data_o, out_chid_o, out_sop_o, out_eop_o
    );
endinterface

// File: rtl/fmt_pkt_sink.sv
// Formatter packet sink: grants whole packets that fit, buffers them, replays on a valid/ready stream.
// Optional FMT_SINK_STATS_EN adds per-channel packet counters on pkt_cnt_o.
module fmt_pkt_sink #(
    parameter int DEPTH     = 64,
    parameter int START_TMO = 15
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    fmt_pkt_sink_if.slave   bus,
    output logic [2:0]      err_o
`ifdef FMT_SINK_STATS_EN
    ,
    output logic [3*16-1:0] pkt_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;

    state_t        state_q;
    logic          grant_q;
    logic [1:0]    chid_q;
    logic [5:0]    len_q;
    logic [5:0]    cnt_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    err_q;
    logic [AW:0]   wrPtr_q;
    logic [AW:0]   rdPtr_q;
    logic [35:0]   mem_q [DEPTH];

    logic [AW:0]   usedWords;
    logic [AW:0]   freeWords;
    logic [AW:0]   lenExt;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          lenLegal;
    logic [5:0]    cnt_d;
    logic          lastWord;
    logic          endMismatch;
    logic          wordIn;
    logic          push;
    logic          pop;
    logic [AW:0]   wrPtr_d;
    logic [AW:0]   rdPtr_d;
    logic [35:0]   headWord;

    assign usedWords = wrPtr_q - rdPtr_q;
    assign freeWords = (AW+1)'(DEPTH) - usedWords;
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign lenExt    = (AW+1)'(bus.fmt_length_i);
    assign lenLegal  = (bus.fmt_length_i != 6'd0) && (lenExt <= (AW+1)'(DEPTH));

    // cnt_q is zero in WAIT_START, so the same end test covers word 0 and later words.
    assign cnt_d       = cnt_q + 6'd1;
    assign lastWord    = bus.fmt_end_i || (cnt_d == len_q);
    assign endMismatch = bus.fmt_end_i != (cnt_d == len_q);
    assign wordIn      = ((state_q == WAIT_START) && bus.fmt_start_i) || (state_q == RECV);
    assign push        = wordIn && !fifoFull;
    assign pop         = !fifoEmpty && bus.out_rdy_i;
    assign wrPtr_d     = wrPtr_q + (AW+1)'(1);
    assign rdPtr_d     = rdPtr_q + (AW+1)'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            chid_q  <= 2'd0;
            len_q   <= 6'd0;
            cnt_q   <= 6'd0;
            tmo_q   <= '0;
            err_q   <= 3'b000;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            grant_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 6'd0;
                    tmo_q <= '0;
                    if (bus.fmt_req_i) begin
                        if (!lenLegal) begin
                            err_q[0] <= 1'b1;
                        end else if (lenExt <= freeWords) begin
                            state_q <= GRANT;
                            grant_q <= 1'b1;
                            chid_q  <= bus.fmt_chid_i;
                            len_q   <= bus.fmt_length_i;
                        end
                    end
                end
                GRANT: begin
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.fmt_start_i) begin
                        cnt_q <= cnt_d;
                        if (lastWord) begin
                            state_q <= IDLE;
                            if (endMismatch) err_q[1] <= 1'b1;
                        end else begin
                            state_q <= RECV;
                        end
                    end else if (tmo_q == TW'(START_TMO - 1)) begin
                        err_q[2] <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                RECV: begin
                    cnt_q <= cnt_d;
                    if (lastWord) begin
                        state_q <= IDLE;
                        if (endMismatch) err_q[1] <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Grant-time space check should make this unreachable; flag it if it ever happens.
            if (wordIn && fifoFull) err_q[1] <= 1'b1;
            if (push) wrPtr_q <= wrPtr_d;
            if (pop)  rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= {chid_q, (state_q == WAIT_START), lastWord, bus.fmt_data_i};
        end
    end

    assign headWord        = mem_q[rdPtr_q[AW-1:0]];
    assign bus.fmt_grant_o = grant_q;
    assign bus.out_vld_o   = !fifoEmpty;
    assign bus.out_data_o  = fifoEmpty ? 32'd0 : headWord[31:0];
    assign bus.out_chid_o  = fifoEmpty ? 2'd0  : headWord[35:34];
    assign bus.out_sop_o   = !fifoEmpty && headWord[33];
    assign bus.out_eop_o   = !fifoEmpty && headWord[32];
    assign err_o           = err_q;

`ifdef FMT_SINK_STATS_EN
    logic [15:0] pktCnt_q [3];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 3; c++) pktCnt_q[c] <= 16'd0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push && lastWord && (chid_q == 2'(c))) pktCnt_q[c] <= pktCnt_q[c] + 16'd1;
            end
        end
    end

    assign pkt_cnt_o = {pktCnt_q[2], pktCnt_q[1], pktCnt_q[0]};
`endif

endmodule
